// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Optional signed support is enabled with DIV_SIGNED_EN.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } divState_e;

  // Quotient bit pattern returned for a zero divisor (all ones).
  localparam logic DIV_ZERO_Q_BIT = 1'b1;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_if.sv
// Start/Busy/Done handshake and operand/result bus of the sequential divider.
// IsSigned and Overflow exist only when DIV_SIGNED_EN is defined.
interface div_if #(parameter int WIDTH = 16);

  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             DivByZero;
`ifdef DIV_SIGNED_EN
  logic             IsSigned;
  logic             Overflow;

  modport master (output Start, A, B, IsSigned,
                  input  Busy, Done, Quotient, Remainder, DivByZero, Overflow);
  modport slave  (input  Start, A, B, IsSigned,
                  output Busy, Done, Quotient, Remainder, DivByZero, Overflow);
`else
  modport master (output Start, A, B,
                  input  Busy, Done, Quotient, Remainder, DivByZero);
  modport slave  (input  Start, A, B,
                  output Busy, Done, Quotient, Remainder, DivByZero);
`endif

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, dvd} left, trial-subtract, select.
// Unaffected by DIV_SIGNED_EN; always works on magnitudes.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] dvdNext
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor is invariant, so WIDTH+1 bits hold the signed trial difference.
  assign shifted = {rem, dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign remNext = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign dvdNext = {dvd[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, Start/Busy/Done handshake.
// Define DIV_SIGNED_EN to add two's-complement operation (IsSigned/Overflow).
//
// state | meaning
// IDLE  | waiting for Start; results held
// CALC  | WIDTH restoring steps, counter WIDTH-1..0
// FIX   | sign correction, results registered
// DONE  | one-cycle Done pulse, Busy low
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic Clk,
  input logic Rst_n,
  div_if.slave bus
);

  localparam int CW = clog2(WIDTH);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_FIX  = FIX;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, divisor;
  logic [WIDTH-1:0] remNext, dvdNext;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH-1:0] quotReg, remReg;
  logic             bZero, negQ, negR, dbzReg;
  logic             isSigned;

`ifdef DIV_SIGNED_EN
  logic ovf, ovfReg;
  assign isSigned     = bus.IsSigned;
  assign bus.Overflow = ovfReg;
`else
  assign isSigned = 1'b0;
`endif

  assign magA = (isSigned && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign magB = (isSigned && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvd     (dvd),
    .divisor (divisor),
    .remNext (remNext),
    .dvdNext (dvdNext)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      divisor <= '0;
      bZero   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      quotReg <= '0;
      remReg  <= '0;
      dbzReg  <= 1'b0;
`ifdef DIV_SIGNED_EN
      ovf     <= 1'b0;
      ovfReg  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            rem     <= '0;
            divisor <= magB;
            bZero   <= (bus.B == '0);
            // Zero divisor keeps the raw dividend, which becomes the remainder.
            dvd     <= (bus.B == '0) ? bus.A : magA;
            negQ    <= isSigned && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            negR    <= isSigned && bus.A[WIDTH-1];
            cnt     <= CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
            ovf     <= isSigned && (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);
`endif
            // Zero divisor skips CALC but still passes FIX, giving a two-edge latency.
            state   <= (bus.B == '0) ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: begin
          rem <= remNext;
          dvd <= dvdNext;
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        ST_FIX: begin
          if (bZero) begin
            quotReg <= {WIDTH{DIV_ZERO_Q_BIT}};
            remReg  <= dvd;
            dbzReg  <= 1'b1;
`ifdef DIV_SIGNED_EN
            ovfReg  <= 1'b0;
`endif
          end else begin
            quotReg <= negQ ? -dvd : dvd;
            remReg  <= negR ? -rem : rem;
            dbzReg  <= 1'b0;
`ifdef DIV_SIGNED_EN
            ovfReg  <= ovf;
`endif
          end
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Busy      = (state == ST_CALC) || (state == ST_FIX);
  assign bus.Done      = (state == ST_DONE);
  assign bus.Quotient  = quotReg;
  assign bus.Remainder = remReg;
  assign bus.DivByZero = dbzReg;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=16); signed cases run when DIV_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int W = 16;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  div_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           acceptEdge;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   edgeCnt = 0;

  always @(posedge Clk) edgeCnt <= edgeCnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t e;
    int   da, db;
    e.q = '0; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0;
    e.acceptEdge = 0;
    e.lat = W + 2;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 2;
    end else if (sgn) begin
      if (a == 16'h8000 && b == 16'hFFFF) begin
        e.q = 16'h8000; e.r = '0; e.ovf = 1'b1;
      end else begin
        da = $signed(a);
        db = $signed(b);
        e.q = W'(da / db);
        e.r = W'(da % db);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Called at a negedge; holds Start for exactly one rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input bit expectAccept);
    exp_t e;
    bus.Start = 1'b1;
    bus.A = a;
    bus.B = b;
`ifdef DIV_SIGNED_EN
    bus.IsSigned = sgn;
`endif
    if (expectAccept) begin
      e = model(a, b, sgn);
      e.acceptEdge = edgeCnt + 1;
      sb.push_back(e);
    end
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (bus.Done !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (bus.Done !== 1'b1) chk("timeout_done", 32'd0, 32'd1);
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    issue(a, b, sgn, 1'b1);
    waitDone(W + 10);
    @(negedge Clk);
  endtask

  // Monitor: every Done pulse is matched against the oldest pending expectation.
  initial begin : monitor
    exp_t e;
    logic prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge Clk);
      if (bus.Done === 1'b1) begin
        chk("done_pulse_width", 32'(prevDone), 32'd0);
        chk("busy_in_done", 32'(bus.Busy), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient", 32'(bus.Quotient), 32'(e.q));
          chk("remainder", 32'(bus.Remainder), 32'(e.r));
          chk("div_by_zero", 32'(bus.DivByZero), 32'(e.dbz));
`ifdef DIV_SIGNED_EN
          chk("overflow", 32'(bus.Overflow), 32'(e.ovf));
`endif
          chk("latency", 32'(edgeCnt - e.acceptEdge + 1), 32'(e.lat));
        end
      end
      prevDone = bus.Done;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stim
    logic [W-1:0] ra, rb;
    logic         rs;
    bus.Start = 1'b0;
    bus.A = '0;
    bus.B = '0;
`ifdef DIV_SIGNED_EN
    bus.IsSigned = 1'b0;
`endif
    repeat (2) @(negedge Clk);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_quotient", 32'(bus.Quotient), 32'd0);
    chk("rst_remainder", 32'(bus.Remainder), 32'd0);
    chk("rst_dbz", 32'(bus.DivByZero), 32'd0);
`ifdef DIV_SIGNED_EN
    chk("rst_overflow", 32'(bus.Overflow), 32'd0);
`endif
    Rst_n = 1'b1;
    @(negedge Clk);

    // 18/4, then a Start held only across the DONE->IDLE edge must be dropped
    issue(16'd18, 16'd4, 1'b0, 1'b1);
    chk("busy_after_accept", 32'(bus.Busy), 32'd1);
    waitDone(W + 10);
    issue(16'd9, 16'd9, 1'b0, 1'b0);
    chk("start_in_done_ignored", 32'(bus.Busy), 32'd0);

    // divide by zero
    runOp(16'd7, 16'd0, 1'b0);

    // Start during Busy ignored, then back-to-back accept right after Done
    issue(16'd18, 16'd3, 1'b0, 1'b1);
    chk("held_while_busy", 32'(bus.Quotient), 32'hFFFF);
    repeat (3) @(negedge Clk);
    issue(16'd5, 16'd2, 1'b0, 1'b0);
    waitDone(W + 10);
    @(negedge Clk);
    runOp(16'd5, 16'd2, 1'b0);

    // max dividend, then reset in the middle of an operation
    runOp(16'hFFFF, 16'd1, 1'b0);
    issue(16'd100, 16'd7, 1'b0, 1'b1);
    repeat (6) @(negedge Clk);
    @(posedge Clk);
    #1 Rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_quotient", 32'(bus.Quotient), 32'd0);
    chk("abort_remainder", 32'(bus.Remainder), 32'd0);
    chk("abort_dbz", 32'(bus.DivByZero), 32'd0);
    repeat (3) @(negedge Clk);
    chk("abort_no_done", 32'(bus.Done), 32'd0);
    Rst_n = 1'b1;
    repeat (W + 4) @(negedge Clk);
    chk("abort_still_idle", 32'(bus.Busy), 32'd0);

    // boundaries
    runOp(16'd5, 16'd9, 1'b0);
    runOp(16'd0, 16'd5, 1'b0);
    runOp(16'hFFFF, 16'hFFFF, 1'b0);
    runOp(16'h8000, 16'hFFFF, 1'b0);
    runOp(16'hFFFE, 16'h8001, 1'b0);

`ifdef DIV_SIGNED_EN
    runOp(16'hFFF9, 16'd2, 1'b1);
    runOp(16'hFFF9, 16'd2, 1'b0);
    runOp(16'h8000, 16'hFFFF, 1'b1);
    runOp(16'd7, 16'hFFFE, 1'b1);
    runOp(16'hFFF9, 16'hFFFE, 1'b1);
    runOp(16'h8000, 16'd0, 1'b1);
`endif

    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      if (i % 5 == 0)      rb = '0;
      else if (i % 2 == 1) rb = W'($urandom_range(1, 20));
      else                 rb = W'($urandom);
`ifdef DIV_SIGNED_EN
      rs = (i % 3 == 0);
`else
      rs = 1'b0;
`endif
      runOp(ra, rb, rs);
    end

    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
